// File: rtl/trig_pulse_gen.sv
// Trigger pulse burst generator: Count pulses of W cycles spaced P cycles apart, or continuous until Stop.
// First pulse rises 1 cycle after Start is sampled in IDLE; no backpressure, Start outside IDLE is ignored.
module trig_pulse_gen #(
   parameter int PERIOD_BITS = 16,
   parameter int WIDTH_BITS  = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Stop,
   input  logic [PERIOD_BITS-1:0] PulseCount,
   input  logic [WIDTH_BITS-1:0]  PulseWidth,
   input  logic [PERIOD_BITS-1:0] PulsePeriod,
   output logic                   TrigPulse,
   output logic                   TRIGB,
   output logic                   Busy,
   output logic                   Done,
   output logic [PERIOD_BITS-1:0] PulsesSent
);

   // Period arithmetic must hold W+1 even when PulseWidth is all-ones.
   localparam int CALC_BITS = (PERIOD_BITS > WIDTH_BITS) ? PERIOD_BITS : WIDTH_BITS + 1;

   localparam logic [WIDTH_BITS-1:0]  W_ONE   = WIDTH_BITS'(1);
   localparam logic [WIDTH_BITS:0]    WP1_ONE = (WIDTH_BITS + 1)'(1);
   localparam logic [CALC_BITS-1:0]   C_ONE   = CALC_BITS'(1);
   localparam logic [PERIOD_BITS-1:0] P_ONE   = PERIOD_BITS'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [PERIOD_BITS-1:0] lat_count;
   logic [WIDTH_BITS-1:0]  lat_width;
   logic [CALC_BITS-1:0]   lat_period;
   logic [WIDTH_BITS-1:0]  width_cnt;
   logic [CALC_BITS-1:0]   gap_cnt;

   logic [WIDTH_BITS-1:0]  width_clamp;
   logic [WIDTH_BITS:0]    width_plus1;
   logic [CALC_BITS-1:0]   period_in;
   logic [CALC_BITS-1:0]   period_clamp;
   logic [CALC_BITS-1:0]   gap_len;
   logic                   last_pulse;

   always_comb begin
      width_clamp  = (PulseWidth == '0) ? W_ONE : PulseWidth;
      width_plus1  = {1'b0, width_clamp} + WP1_ONE;
      period_in    = CALC_BITS'(PulsePeriod);
      period_clamp = (period_in > CALC_BITS'(width_plus1)) ? period_in : CALC_BITS'(width_plus1);
      gap_len      = lat_period - CALC_BITS'(lat_width);
      last_pulse   = (lat_count != '0) && (PulsesSent == lat_count);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         TrigPulse  <= 1'b0;
         TRIGB      <= 1'b1;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         PulsesSent <= '0;
         lat_count  <= '0;
         lat_width  <= '0;
         lat_period <= '0;
         width_cnt  <= '0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start && !Stop) begin
                  lat_count  <= PulseCount;
                  lat_width  <= width_clamp;
                  lat_period <= period_clamp;
                  width_cnt  <= width_clamp - W_ONE;
                  PulsesSent <= P_ONE;
                  TrigPulse  <= 1'b1;
                  TRIGB      <= 1'b0;
                  Busy       <= 1'b1;
                  state      <= HIGH;
               end
            end

            HIGH: begin
               // Stop is only honoured once the pulse has run its full width.
               if (width_cnt != '0) begin
                  width_cnt <= width_cnt - W_ONE;
               end else begin
                  TrigPulse <= 1'b0;
                  TRIGB     <= 1'b1;
                  if (last_pulse || Stop) begin
                     Done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     gap_cnt <= gap_len - C_ONE;
                     state   <= GAP;
                  end
               end
            end

            GAP: begin
               if (Stop) begin
                  Done  <= 1'b1;
                  state <= DONE;
               end else if (gap_cnt == '0) begin
                  width_cnt  <= lat_width - W_ONE;
                  PulsesSent <= PulsesSent + P_ONE;
                  TrigPulse  <= 1'b1;
                  TRIGB      <= 1'b0;
                  state      <= HIGH;
               end else begin
                  gap_cnt <= gap_cnt - C_ONE;
               end
            end

            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_trigb_inverse: assert property (@(posedge Clk) disable iff (Reset) TRIGB == !TrigPulse);
   a_busy_state:    assert property (@(posedge Clk) disable iff (Reset) Busy == (state != IDLE));
   a_done_state:    assert property (@(posedge Clk) disable iff (Reset) Done == (state == DONE));

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Bench for trig_pulse_gen: directed bursts with literal expectations plus randomized traffic vs a pulse-train model.
module tb_trig_pulse_gen;
   localparam int PB = 8;
   localparam int WB = 8;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          Stop;
   logic [PB-1:0] PulseCount;
   logic [WB-1:0] PulseWidth;
   logic [PB-1:0] PulsePeriod;
   logic          TrigPulse;
   logic          TRIGB;
   logic          Busy;
   logic          Done;
   logic [PB-1:0] PulsesSent;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   trig_pulse_gen #(.PERIOD_BITS(PB), .WIDTH_BITS(WB)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
      .PulseCount(PulseCount), .PulseWidth(PulseWidth), .PulsePeriod(PulsePeriod),
      .TrigPulse(TrigPulse), .TRIGB(TRIGB), .Busy(Busy), .Done(Done), .PulsesSent(PulsesSent)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Model: a burst is a pulse train indexed by k = cycles since the first pulse.
   // Pulse i occupies k in [i*P, i*P+W); the burst ends after the pulse whose
   // index reaches Count, or at Stop (end of the current pulse, or at once in a gap).
   bit            m_run  = 1'b0;
   bit            m_done = 1'b0;
   int            m_k, m_w, m_p, m_n, m_ph;
   bit            m_last;
   logic          m_et;
   logic [PB-1:0] m_sent = '0;

   always @(posedge Clk) begin
      if (Reset) begin
         m_run  = 1'b0;
         m_done = 1'b0;
         m_sent = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_run) begin
         if (Start && !Stop) begin
            m_w    = (PulseWidth == '0) ? 1 : int'(PulseWidth);
            m_p    = (int'(PulsePeriod) > m_w + 1) ? int'(PulsePeriod) : m_w + 1;
            m_n    = int'(PulseCount);
            m_k    = 0;
            m_run  = 1'b1;
            m_sent = PB'(1);
         end
      end else begin
         m_ph   = m_k % m_p;
         m_last = (m_n != 0) && (m_k / m_p + 1 == m_n);
         if ((m_ph == m_w - 1 && (m_last || Stop)) || (m_ph >= m_w && Stop)) begin
            m_run  = 1'b0;
            m_done = 1'b1;
         end else begin
            m_k++;
            m_sent = PB'(m_k / m_p + 1);
         end
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         m_et = m_run ? ((m_k % m_p) < m_w) : 1'b0;
         chk("model_trig",  32'(TrigPulse),  32'(m_et));
         chk("model_trigb", 32'(TRIGB),      32'(!m_et));
         chk("model_busy",  32'(Busy),       32'(m_run || m_done));
         chk("model_done",  32'(Done),       32'(m_done));
         chk("model_sent",  32'(PulsesSent), 32'(m_sent));
      end
   end

   logic [31:0]   trm, dnm, bzm;
   logic [PB-1:0] ps_h [0:19];
   logic          tb_h [0:19];

   // Runs 20 cycles starting in an idle cycle (cycle 0 carries Start) and records outputs.
   task automatic burst(input int cnt, input int w, input int p, input int stop_at,
                        input int rst_at, input int restart_at, input bit scramble);
      trm = '0; dnm = '0; bzm = '0;
      PulseCount  = PB'(cnt);
      PulseWidth  = WB'(w);
      PulsePeriod = PB'(p);
      Start = 1'b1;
      Stop  = (stop_at == 0);
      Reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         trm[c]  = TrigPulse;
         dnm[c]  = Done;
         bzm[c]  = Busy;
         ps_h[c] = PulsesSent;
         tb_h[c] = TRIGB;
         @(posedge Clk); #1;
         Start = (c + 1 == restart_at);
         Stop  = (stop_at >= 0) && (c + 1 >= stop_at);
         Reset = (c + 1 == rst_at);
         if (scramble && c + 1 == 3) begin
            PulseCount  = PB'(7);
            PulseWidth  = WB'(9);
            PulsePeriod = PB'(1);
         end
      end
      Start = 1'b0;
      Stop  = 1'b0;
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; Stop = 1'b0;
      PulseCount = '0; PulseWidth = '0; PulsePeriod = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk_en = 1'b1;
      @(negedge Clk);
      chk("rst_trig",  32'(TrigPulse),  32'd0);
      chk("rst_trigb", 32'(TRIGB),      32'd1);
      chk("rst_busy",  32'(Busy),       32'd0);
      chk("rst_done",  32'(Done),       32'd0);
      chk("rst_sent",  32'(PulsesSent), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;

      // Count=3, W=2, P=5
      burst(3, 2, 5, -1, -1, -1, 1'b0);
      chk("b030_trig", trm, 32'h0000_18C6);
      chk("b030_done", dnm, 32'h0000_2000);
      chk("b030_busy", bzm, 32'h0000_3FFE);
      chk("b030_sent", 32'(ps_h[19]), 32'd3);
      chk("b030_trigb_c1", 32'(tb_h[1]), 32'd0);

      // Zero width/period clamp to W=1, P=2
      burst(2, 0, 0, -1, -1, -1, 1'b0);
      chk("b031_trig", trm, 32'h0000_000A);
      chk("b031_done", dnm, 32'h0000_0010);
      chk("b031_busy", bzm, 32'h0000_001E);

      // Continuous, Stop raised in a gap
      burst(0, 1, 4, 6, -1, -1, 1'b0);
      chk("b032_trig", trm, 32'h0000_0022);
      chk("b032_done", dnm, 32'h0000_0080);
      chk("b032_busy", bzm, 32'h0000_00FE);
      chk("b032_sent", 32'(ps_h[19]), 32'd2);

      // Continuous, Stop raised mid-pulse: pulse runs to full width
      burst(0, 4, 10, 2, -1, -1, 1'b0);
      chk("b033_trig", trm, 32'h0000_001E);
      chk("b033_done", dnm, 32'h0000_0020);
      chk("b033_busy", bzm, 32'h0000_003E);
      chk("b033_sent", 32'(ps_h[19]), 32'd1);

      // Start with Stop in IDLE: nothing launches
      burst(3, 2, 5, 0, -1, -1, 1'b0);
      chk("b034_startstop_trig", trm, 32'h0);
      chk("b034_startstop_busy", bzm, 32'h0);
      chk("b034_startstop_done", dnm, 32'h0);

      // Re-Start and config churn while busy leave the burst unchanged
      burst(3, 2, 5, -1, -1, 4, 1'b1);
      chk("b034_restart_trig", trm, 32'h0000_18C6);
      chk("b034_restart_done", dnm, 32'h0000_2000);
      chk("b034_restart_sent", 32'(ps_h[19]), 32'd3);

      // Reset mid-burst
      burst(3, 2, 5, -1, 7, -1, 1'b0);
      chk("b035_trig", trm, 32'h0000_00C6);
      chk("b035_done", dnm, 32'h0);
      chk("b035_busy", bzm, 32'h0000_00FE);
      chk("b035_sent_c8",  32'(ps_h[8]), 32'd0);
      chk("b035_trigb_c8", 32'(tb_h[8]), 32'd1);

      // Continuous W=1 P=2: PulsesSent wraps after 2^PB pulses
      PulseCount = '0; PulseWidth = WB'(1); PulsePeriod = PB'(2);
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (510) @(posedge Clk);
      @(negedge Clk);
      chk("wrap_sent_c511", 32'(PulsesSent), 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("wrap_sent_c513", 32'(PulsesSent), 32'd1);
      @(posedge Clk); #1;
      Stop = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      Stop = 1'b0;
      @(posedge Clk); #1;

      // All-ones width: W=255 forces P=256 without overflow
      PulseCount = PB'(2); PulseWidth = '1; PulsePeriod = PB'(3);
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (255) @(posedge Clk);
      @(negedge Clk);
      chk("wide_gap_trig_c256", 32'(TrigPulse), 32'd0);
      chk("wide_gap_busy_c256", 32'(Busy),      32'd1);
      repeat (256) @(posedge Clk);
      @(negedge Clk);
      chk("wide_done_c512", 32'(Done), 32'd1);
      @(posedge Clk); #1;

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         Reset = ($urandom_range(0, 299) == 0);
         Start = ($urandom_range(0, 3) == 0);
         Stop  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) begin
            PulseCount  = PB'($urandom_range(0, 4));
            PulseWidth  = WB'($urandom_range(0, 5));
            PulsePeriod = PB'($urandom_range(0, 12));
         end
         @(posedge Clk); #1;
      end
      Reset = 1'b0; Start = 1'b0; Stop = 1'b1;
      repeat (20) @(posedge Clk);
      #1;
      Stop = 1'b0;
      @(negedge Clk);
      chk("final_idle_busy", 32'(Busy), 32'd0);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
